// File: rtl/mem_arb_pkg.sv
// Shared encodings for the main-memory arbiter: FSM states and access owners.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DSP = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: req[0] is the CPU, req[1] the display fetch engine.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_owner
);

  always_comb begin
    gnt_valid = |req;
    gnt_owner = OWN_CPU;
    // On a tie the requester that did not win last time gets the memory
    if (req == 2'b11) begin
      gnt_owner = ~last_grant;
    end else if (req[1]) begin
      gnt_owner = OWN_DSP;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main memory between the CPU datapath and the LCD display fetch,
// running a MEM_LAT-cycle access and producing the controller's wait_ hold.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              wait_,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic              dsp_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t            state, state_nxt;
  owner_t            owner, last_grant;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q;
  logic              gnt_valid;
  logic              gnt_owner;

  rr_arbiter2 u_rr (
    .req        ({dsp_req, cpu_req}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_owner  (gnt_owner)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_valid) state_nxt = ACCESS;
      ACCESS:  if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_CPU;
      last_grant <= OWN_DSP;
      cnt        <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      cpu_rdata  <= '0;
      dsp_rdata  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            owner <= owner_t'(gnt_owner);
            // Display path is read-only, so its accesses never write
            addr_q  <= gnt_owner ? dsp_addr : cpu_addr;
            we_q    <= ~gnt_owner & cpu_we;
            wdata_q <= gnt_owner ? '0 : cpu_wdata;
            cnt     <= CNT_W'(MEM_LAT - 1);
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            last_grant <= owner;
            if (owner == OWN_DSP) begin
              dsp_rdata <= mem_rdata;
            end else if (!we_q) begin
              cpu_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_en    = (state == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dsp_ack   = (state == DONE) && (owner == OWN_DSP);
  // Controller holds its microstate until the CPU's own DONE cycle
  assign wait_     = cpu_req && !((state == DONE) && (owner == OWN_CPU));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT=2 plus a MEM_LAT=1 instance.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        wait_;
  logic        dsp_req;
  logic [15:0] dsp_addr, dsp_rdata;
  logic        dsp_ack;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  logic        c1_cpu_req, c1_cpu_we;
  logic [15:0] c1_cpu_addr, c1_cpu_wdata, c1_cpu_rdata;
  logic        c1_wait;
  logic        c1_dsp_req;
  logic [15:0] c1_dsp_addr, c1_dsp_rdata;
  logic        c1_dsp_ack;
  logic        c1_mem_en, c1_mem_we;
  logic [15:0] c1_mem_addr, c1_mem_wdata, c1_mem_rdata;

  logic [15:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;

  int errors = 0;
  int checks = 0;

  localparam logic [3:0] EXP_EN4   = 4'b0110;
  localparam logic [3:0] EXP_WAIT4 = 4'b0111;
  localparam logic [3:0] EXP_ACK4  = 4'b1000;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(2)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .wait_(wait_),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr), .dsp_rdata(dsp_rdata),
    .dsp_ack(dsp_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .cpu_req(c1_cpu_req), .cpu_we(c1_cpu_we), .cpu_addr(c1_cpu_addr),
    .cpu_wdata(c1_cpu_wdata), .cpu_rdata(c1_cpu_rdata), .wait_(c1_wait),
    .dsp_req(c1_dsp_req), .dsp_addr(c1_dsp_addr), .dsp_rdata(c1_dsp_rdata),
    .dsp_ack(c1_dsp_ack),
    .mem_en(c1_mem_en), .mem_we(c1_mem_we), .mem_addr(c1_mem_addr),
    .mem_wdata(c1_mem_wdata), .mem_rdata(c1_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
  end
  assign mem_rdata    = mem_en ? mem[mem_addr[7:0]] : 16'h0000;
  assign c1_mem_rdata = c1_mem_en ? {c1_mem_addr[7:0], 8'hA5} : 16'h0000;

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({mem_en, mem_we, dsp_ack, wait_, cpu_rdata, dsp_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%b we=%b ack=%b wait=%b crd=%h drd=%h addr=%h wd=%h, required all 0",
               mem_en, mem_we, dsp_ack, wait_, cpu_rdata, dsp_rdata, mem_addr, mem_wdata);
    end
    checks++;
    if ({c1_mem_en, c1_dsp_ack, c1_wait, c1_cpu_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_lat1: en=%b ack=%b wait=%b crd=%h, required all 0",
               c1_mem_en, c1_dsp_ack, c1_wait, c1_cpu_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_cpu_read();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (mem_en !== EXP_EN4[c]) begin
        errors++;
        $display("FAIL cpu_read_en c%0d: got %b, required %b", c, mem_en, EXP_EN4[c]);
      end
      checks++;
      if (wait_ !== EXP_WAIT4[c]) begin
        errors++;
        $display("FAIL cpu_read_wait c%0d: got %b, required %b", c, wait_, EXP_WAIT4[c]);
      end
    end
    checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL cpu_read_data: got %h, required beef", cpu_rdata);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_write();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 16'h1234;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (wait_ !== EXP_WAIT4[c]) begin
        errors++;
        $display("FAIL cpu_write_wait c%0d: got %b, required %b", c, wait_, EXP_WAIT4[c]);
      end
      if (c == 1 || c == 2) begin
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0020, 16'h1234}) begin
          errors++;
          $display("FAIL cpu_write_bus c%0d: en=%b we=%b addr=%h wd=%h, required 1 1 0020 1234",
                   c, mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
    end
    checks++;
    if (cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL cpu_write_rdata: got %h, required beef (unchanged)", cpu_rdata);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0020;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wait_, cpu_rdata} !== {1'b0, 16'h1234}) begin
      errors++;
      $display("FAIL cpu_write_readback: wait=%b data=%h, required 0 1234", wait_, cpu_rdata);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_tie();
    apply_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    dsp_req = 1'b1; dsp_addr = 16'h8000;
    for (int c = 0; c < 9; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      case (c)
        1: begin
          checks++;
          if (mem_addr !== 16'h0030) begin
            errors++;
            $display("FAIL tie_first_grant: addr=%h, required 0030 (cpu)", mem_addr);
          end
        end
        3: begin
          checks++;
          if ({wait_, dsp_ack, cpu_rdata} !== {1'b0, 1'b0, 16'h3333}) begin
            errors++;
            $display("FAIL tie_cpu_done: wait=%b ack=%b data=%h, required 0 0 3333", wait_, dsp_ack, cpu_rdata);
          end
          cpu_req = 1'b0;
        end
        4: begin
          checks++;
          if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL tie_bubble: en=%b, required 0", mem_en);
          end
        end
        5: begin
          checks++;
          if ({mem_en, mem_addr} !== {1'b1, 16'h8000}) begin
            errors++;
            $display("FAIL tie_second_grant: en=%b addr=%h, required 1 8000", mem_en, mem_addr);
          end
        end
        7: begin
          checks++;
          if ({dsp_ack, dsp_rdata} !== {1'b1, 16'h00FF}) begin
            errors++;
            $display("FAIL tie_dsp_ack: ack=%b data=%h, required 1 00ff", dsp_ack, dsp_rdata);
          end
          dsp_req = 1'b0;
        end
        8: begin
          checks++;
          if (dsp_ack !== 1'b0) begin
            errors++;
            $display("FAIL tie_ack_pulse: ack=%b, required 0", dsp_ack);
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic own;
    n = 0;
    apply_reset();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0030;
    dsp_req = 1'b1; dsp_addr = 16'h8000;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (dsp_ack || (cpu_req && !wait_)) begin
        own = dsp_ack;
        checks++;
        if (own !== n[0] || c != 4 * n + 3) begin
          errors++;
          $display("FAIL b2b_grant%0d: owner=%0d at cycle %0d, required owner %0d at cycle %0d",
                   n, own, c, n[0], 4 * n + 3);
        end
        n++;
      end
    end
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL b2b_count: %0d completions, required 10", n);
    end
    cpu_req = 1'b0; dsp_req = 1'b0;
  endtask

  task automatic test_dsp_read();
    apply_reset();
    @(negedge clk);
    dsp_req = 1'b1; dsp_addr = 16'h8000;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({wait_, dsp_ack} !== {1'b0, (c < 4) ? EXP_ACK4[c] : 1'b0}) begin
        errors++;
        $display("FAIL dsp_read c%0d: wait=%b ack=%b, required 0 %b", c, wait_, dsp_ack,
                 (c < 4) ? EXP_ACK4[c] : 1'b0);
      end
      if (c == 3) begin
        checks++;
        if (dsp_rdata !== 16'h00FF) begin
          errors++;
          $display("FAIL dsp_read_data: got %h, required 00ff", dsp_rdata);
        end
        dsp_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    @(negedge clk);
    dsp_req = 1'b1; dsp_addr = 16'h8000;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (mem_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: en=%b, required 1", mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_en, dsp_ack} !== 2'b00) begin
      errors++;
      $display("FAIL abort_en: en=%b ack=%b, required 0 0", mem_en, dsp_ack);
    end
    rst = 1'b0; dsp_req = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({mem_en, dsp_ack, dsp_rdata} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL abort_no_ack: en=%b ack=%b data=%h, required 0 0 0000", mem_en, dsp_ack, dsp_rdata);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({wait_, cpu_rdata} !== {1'b0, 16'hBEEF}) begin
      errors++;
      $display("FAIL abort_recover: wait=%b data=%h, required 0 beef", wait_, cpu_rdata);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_lat1();
    @(negedge clk);
    c1_cpu_req = 1'b1; c1_cpu_we = 1'b0; c1_cpu_addr = 16'h0040;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if ({c1_mem_en, c1_wait} !== {(c == 1), (c < 2) && c1_cpu_req}) begin
        errors++;
        $display("FAIL lat1 c%0d: en=%b wait=%b, required %b %b", c, c1_mem_en, c1_wait,
                 (c == 1), (c < 2) && c1_cpu_req);
      end
      if (c == 2) begin
        checks++;
        if ({c1_cpu_rdata, c1_dsp_ack, c1_mem_we} !== {16'h40A5, 1'b0, 1'b0}) begin
          errors++;
          $display("FAIL lat1_data: data=%h ack=%b we=%b, required 40a5 0 0", c1_cpu_rdata, c1_dsp_ack, c1_mem_we);
        end
        c1_cpu_req = 1'b0;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dsp_req = 1'b0; dsp_addr = '0;
    c1_cpu_req = 1'b0; c1_cpu_we = 1'b0; c1_cpu_addr = '0; c1_cpu_wdata = '0;
    c1_dsp_req = 1'b0; c1_dsp_addr = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;

    test_reset();
    preload(8'h10, 16'hBEEF);
    preload(8'h30, 16'h3333);
    preload(8'h00, 16'h00FF);
    test_cpu_read();
    test_cpu_write();
    test_tie();
    test_back_to_back();
    test_dsp_read();
    test_reset_mid();
    test_lat1();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared main memory between two requesters: the CPU datapath (driven by the microprogrammed controller) and the LCD display-fetch engine.
- Runs a multi-cycle memory access and produces the wait_ signal that the controller branches on to hold its microstate.
- Sits between the controller/datapath, the display fetch unit, and the memory macro.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- MEM_LAT, 2, cycles mem_en is held per access (legal range >=1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  CPU access request; held high until wait_ is seen low.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  CPU read data; valid in the cycle wait_ falls with cpu_req high.
- wait_  out  1  1 = CPU access not complete, controller must hold.
- dsp_req  in  1  display read request; held until dsp_ack.
- dsp_addr  in  ADDR_W  display read address.
- dsp_rdata  out  DATA_W  display read data; valid with dsp_ack.
- dsp_ack  out  1  one-cycle completion pulse.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid on the final MEM_LAT cycle.

Behaviour:
- Reset: state IDLE; mem_en, mem_we, dsp_ack = 0; cpu_rdata, dsp_rdata, mem_addr, mem_wdata = 0; last_grant = DSP, so the CPU wins the first tie.
- Reset mid-access: the access is aborted. mem_en is 0 in the cycle after rst. No ack is issued and wait_ does not fall for the aborted access.
- FSM state IDLE:
  - If any request is high, latch owner, address, we and wdata into registers, load cnt = MEM_LAT-1, and go to ACCESS.
  - Tie between requesters goes to the owner that is not last_grant (round robin).
  - The display requester is read-only: mem_we is forced to 0 for display accesses.
- FSM state ACCESS:
  - mem_en = 1 and mem_addr/mem_we/mem_wdata are driven from the latched registers.
  - cnt decrements each cycle.
  - When cnt == 0: capture mem_rdata into the owner's rdata register, set last_grant = owner, and go to DONE.
- FSM state DONE (one cycle):
  - mem_en = 0.
  - Display owner: dsp_ack = 1. CPU owner: completion is signalled via wait_.
  - Next state is IDLE. A new grant is only evaluated in IDLE, giving one bubble cycle between accesses.
- Latency: from request seen in IDLE to completion is 1 + MEM_LAT + 1 cycles (4 at the default MEM_LAT).
- wait_ is combinational: wait_ = cpu_req AND NOT (state == DONE AND owner == CPU).
  - wait_ is 0 whenever cpu_req is low.
  - The CPU must drop cpu_req or change its request after the completion cycle. If cpu_req is still high in the following IDLE, it is treated as a new access.
- Requester inputs are sampled only in IDLE. Changes during ACCESS are ignored.
- dsp_req held high after dsp_ack counts as a new request.
- Starvation bound: with both requesters continuously active, grants alternate. Worst-case CPU wait is 2 × (MEM_LAT + 2) cycles.
- A write to a read-only requester path is impossible by construction. A CPU write returns cpu_rdata unchanged, with no capture.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encoding IDLE/ACCESS/DONE (2 bits);
  - owner encoding OWN_CPU = 0, OWN_DSP = 1.
- One sub-module, rr_arbiter2: a two-way round-robin grant from req[1:0] and last_grant, combinational.
- The latency counter and FSM stay in mem_arbiter.

Test Plan:
- CPU read alone, addr 0x0010, memory returns 0xBEEF: mem_en high exactly 2 cycles; wait_ = 1 for 3 cycles, then 0 with cpu_rdata = 0xBEEF.
- CPU write, addr 0x0020, data 0x1234: mem_we = 1, mem_wdata = 0x1234 during ACCESS; memory model reads back 0x1234; cpu_rdata unchanged.
- Simultaneous cpu_req and dsp_req after reset: CPU granted first, then display. dsp_ack occurs 4 cycles after CPU completion, and grants alternate over 10 back-to-back requests.
- Display read, addr 0x8000 -> 0x00FF: dsp_ack single-cycle pulse with dsp_rdata = 0x00FF; wait_ stays 0 with cpu_req low.
- rst asserted during the 2nd ACCESS cycle: mem_en = 0 in the next cycle, no dsp_ack or completion; a fresh request afterwards completes normally.
- MEM_LAT = 1 build: request-to-completion = 3 cycles; mem_en is a 1-cycle pulse.
